triangle_setup: RTL and testbench
=================================

// Module: triangle_setup
// PURPOSE
//  Per-triangle setup stage directly upstream of the rasterizer.
//  - Accepts three screen-space vertices, a colour and three depths.
//  - Computes twice the signed area with a cross product and takes its absolute value.
//  - Culls degenerate triangles (zero area).
//  - Produces inv_area = floor(2^FRAC_BITS / |2A|) with a sequential restoring divider.
//  - Presents the triangle to the rasterizer on a valid/ready handshake.
// PARAMETERS
//  XW         10  signed vertex X width (320-wide target)
//  YW         9   signed vertex Y width (240-tall target)
//  ZW         16  per-vertex depth width
//  CW         8   colour width (RRRGGGBB)
//  FRAC_BITS  24  fractional bits of inv_area (8.24 format)
// PORTS
//  axi_aclk      in   1        clock
//  axi_aresetn   in   1        async active-low reset
//  in_valid      in   1        upstream triangle valid
//  in_ready      out  1        setup idle, can accept
//  in_x          in   3*XW     {x3,x2,x1}, signed
//  in_y          in   3*YW     {y3,y2,y1}, signed
//  in_z          in   3*ZW     {z3,z2,z1}, unsigned
//  in_color      in   CW       flat colour
//  tri_valid     out  1        triangle + inv_area ready for rasterizer
//  tri_ready     in   1        rasterizer can accept
//  tri_x         out  3*XW     registered copy of in_x
//  tri_y         out  3*YW     registered copy of in_y
//  tri_z         out  3*ZW     registered copy of in_z
//  tri_color     out  CW       registered copy of in_color
//  inv_area      out  32       floor(2^FRAC_BITS/|2A|), zero-extended
//  cull_pulse    out  1        1-cycle pulse when a zero-area triangle is dropped
//  cull_count    out  16       saturating count of culled triangles
// BEHAVIOUR
//  Reset (async, axi_aresetn=0):
//   - state=IDLE, in_ready=1, tri_valid=0, cull_pulse=0, cull_count=0.
//   - All tri_* outputs and inv_area = 0.
//   - Any triangle in flight is discarded; no partial output ever appears.
//  FSM: IDLE -> AREA -> DIV -> OUT -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: capture all inputs into the tri_* registers, go to AREA.
//  AREA (1 cycle):
//   - 2A = x1*(y2-y3) + x2*(y3-y1) + x3*(y1-y2), signed, width AW=XW+YW+2.
//   - Register |2A|. Differences are computed sign-extended to YW+1 bits; no overflow is possible.
//   - |2A|==0: pulse cull_pulse, cull_count+=1 (saturates at 16'hFFFF), go to IDLE. tri_valid is never raised.
//   - Otherwise go to DIV.
//  DIV:
//   - Restoring division of 2^FRAC_BITS by |2A|, one quotient bit per cycle, MSB first.
//   - FRAC_BITS+1 cycles, then go to OUT.
//   - Truncation, not rounding; the remainder is discarded.
//  OUT:
//   - tri_valid=1.
//   - All tri_* and inv_area stay stable while tri_valid && !tri_ready.
//   - On tri_valid&&tri_ready: go to IDLE. tri_valid=0 on the next cycle.
//  Latency: tri_valid rises FRAC_BITS+2 clock edges after the accept edge (26 at default).
//  in_ready=0 in AREA/DIV/OUT. No pipelining: one triangle in flight.
//  Back-to-back throughput is FRAC_BITS+4 cycles per triangle with tri_ready held at 1.
//  Winding order is irrelevant: CW and CCW triangles give identical inv_area.
//  in_valid is ignored outside IDLE. Inputs may change freely after the accept edge.
// TESTING
//  1. (100,50),(200,150),(100,150), colour E0, z=50,50,50 -> |2A|=10000, inv_area=1677; tri_valid on edge 26; tri_* echo inputs.
//  2. (200,50),(150,100),(250,100), colour 1C (CW winding) -> |2A|=5000, inv_area=3355; same result with v2/v3 swapped.
//  3. (0,0),(1,0),(0,1) -> |2A|=1, inv_area=32'h0100_0000. Max-area triangle (-512,-256),(511,-256),(-512,255) -> result checked against the reference model floor().
//  4. Collinear (0,0),(10,10),(20,20) -> cull_pulse for exactly 1 cycle, cull_count 0->1, tri_valid stays 0, in_ready back to 1 two edges after accept.
//  5. Backpressure: tri_ready=0 for 10 cycles in OUT -> tri_valid, tri_* and inv_area stable; in_valid pulses ignored; accepted on the first cycle tri_ready=1.
//  6. Reset asserted mid-DIV (cycle 12) -> all outputs at reset values immediately; after release, the next triangle is processed correctly and no stale tri_valid appears.

Source files
------------

// File: rtl/triangle_setup.sv
// Triangle setup stage: twice-area cross product, zero-area cull and
// sequential reciprocal of |2A| ahead of the rasterizer.
module triangle_setup #(
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int ZW        = 16,
    parameter int CW        = 8,
    parameter int FRAC_BITS = 24
) (
    input  logic            axi_aclk,
    input  logic            axi_aresetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*XW-1:0] in_x,
    input  logic [3*YW-1:0] in_y,
    input  logic [3*ZW-1:0] in_z,
    input  logic [CW-1:0]   in_color,
    output logic            tri_valid,
    input  logic            tri_ready,
    output logic [3*XW-1:0] tri_x,
    output logic [3*YW-1:0] tri_y,
    output logic [3*ZW-1:0] tri_z,
    output logic [CW-1:0]   tri_color,
    output logic [31:0]     inv_area,
    output logic            cull_pulse,
    output logic [15:0]     cull_count
);

    localparam int AW   = XW + YW + 2;
    localparam int CNTW = $clog2(FRAC_BITS + 1);

    typedef enum logic [1:0] {IDLE, AREA, DIV, OUT} state_t;

    state_t state_q, state_d;

    logic [3*XW-1:0]    tri_x_q;
    logic [3*YW-1:0]    tri_y_q;
    logic [3*ZW-1:0]    tri_z_q;
    logic [CW-1:0]      tri_color_q;
    logic [31:0]        inv_area_q;
    logic               cull_pulse_q;
    logic [15:0]        cull_count_q;
    logic [AW-1:0]      area_q;
    logic [AW-1:0]      rem_q;
    logic [FRAC_BITS-1:0] quo_q;
    logic [CNTW-1:0]    cnt_q;

    logic signed [AW-1:0] x1e, x2e, x3e;
    logic signed [AW-1:0] d23, d31, d12;
    logic signed [AW-1:0] area_s;
    logic [AW-1:0]        area_abs;
    logic                 area_zero;

    logic [AW:0]   rem_sh;
    logic [AW:0]   rem_sub;
    logic [AW-1:0] rem_nxt;
    logic          ge;
    logic          last;

    // Cross product on the captured vertices; AW bits cannot overflow.
    assign x1e = AW'($signed(tri_x_q[XW-1:0]));
    assign x2e = AW'($signed(tri_x_q[2*XW-1:XW]));
    assign x3e = AW'($signed(tri_x_q[3*XW-1:2*XW]));
    assign d23 = AW'($signed(tri_y_q[2*YW-1:YW]))
               - AW'($signed(tri_y_q[3*YW-1:2*YW]));
    assign d31 = AW'($signed(tri_y_q[3*YW-1:2*YW]))
               - AW'($signed(tri_y_q[YW-1:0]));
    assign d12 = AW'($signed(tri_y_q[YW-1:0]))
               - AW'($signed(tri_y_q[2*YW-1:YW]));

    assign area_s    = x1e * d23 + x2e * d31 + x3e * d12;
    assign area_abs  = area_s[AW-1] ? AW'(-area_s) : AW'(area_s);
    assign area_zero = (area_abs == '0);

    // Dividend is 2^FRAC_BITS: a single 1 fed in on the first step.
    assign rem_sh  = {rem_q, (cnt_q == '0)};
    assign rem_sub = rem_sh - {1'b0, area_q};
    assign ge      = (rem_sh >= {1'b0, area_q});
    assign rem_nxt = ge ? rem_sub[AW-1:0] : rem_sh[AW-1:0];
    assign last    = (cnt_q == CNTW'(FRAC_BITS));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = AREA;
            AREA: state_d = area_zero ? IDLE : DIV;
            DIV:  if (last) state_d = OUT;
            OUT:  if (tri_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tri_x_q      <= '0;
            tri_y_q      <= '0;
            tri_z_q      <= '0;
            tri_color_q  <= '0;
            inv_area_q   <= '0;
            cull_pulse_q <= 1'b0;
            cull_count_q <= '0;
            area_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
        end else begin
            cull_pulse_q <= 1'b0;
            if (state_q == IDLE && in_valid) begin
                tri_x_q     <= in_x;
                tri_y_q     <= in_y;
                tri_z_q     <= in_z;
                tri_color_q <= in_color;
            end
            if (state_q == AREA) begin
                area_q <= area_abs;
                rem_q  <= '0;
                quo_q  <= '0;
                cnt_q  <= '0;
                if (area_zero) begin
                    cull_pulse_q <= 1'b1;
                    if (cull_count_q != 16'hFFFF) begin
                        cull_count_q <= cull_count_q + 16'd1;
                    end
                end
            end
            if (state_q == DIV) begin
                rem_q <= rem_nxt;
                quo_q <= {quo_q[FRAC_BITS-2:0], ge};
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    inv_area_q <= 32'({quo_q, ge});
                end
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign tri_valid  = (state_q == OUT);
    assign tri_x      = tri_x_q;
    assign tri_y      = tri_y_q;
    assign tri_z      = tri_z_q;
    assign tri_color  = tri_color_q;
    assign inv_area   = inv_area_q;
    assign cull_pulse = cull_pulse_q;
    assign cull_count = cull_count_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Scoreboard bench for triangle_setup: directed cases plus randomized
// triangles checked against an integer shoelace/reciprocal model.
module tb_triangle_setup;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int ZW = 16;
    localparam int CW = 8;
    localparam int FB = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3*XW-1:0] in_x = '0;
    logic [3*YW-1:0] in_y = '0;
    logic [3*ZW-1:0] in_z = '0;
    logic [CW-1:0]   in_color = '0;
    logic            tri_valid;
    logic            tri_ready;
    logic [3*XW-1:0] tri_x;
    logic [3*YW-1:0] tri_y;
    logic [3*ZW-1:0] tri_z;
    logic [CW-1:0]   tri_color;
    logic [31:0]     inv_area;
    logic            cull_pulse;
    logic [15:0]     cull_count;

    logic tr_fixed = 1'b1;
    logic bp_rand  = 1'b1;
    bit   rand_bp  = 1'b0;
    assign tri_ready = rand_bp ? bp_rand : tr_fixed;

    always #5 clk = ~clk;

    triangle_setup #(
        .XW(XW), .YW(YW), .ZW(ZW), .CW(CW), .FRAC_BITS(FB)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .in_color    (in_color),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_x       (tri_x),
        .tri_y       (tri_y),
        .tri_z       (tri_z),
        .tri_color   (tri_color),
        .inv_area    (inv_area),
        .cull_pulse  (cull_pulse),
        .cull_count  (cull_count)
    );

    typedef struct {
        logic [3*XW-1:0] x;
        logic [3*YW-1:0] y;
        logic [3*ZW-1:0] z;
        logic [CW-1:0]   c;
        logic [31:0]     inv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    int   exp_cull = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bp_rand = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(string name, longint act, longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3*XW-1:0] px(int a, int b, int c);
        return {XW'(c), XW'(b), XW'(a)};
    endfunction

    function automatic logic [3*YW-1:0] py(int a, int b, int c);
        return {YW'(c), YW'(b), YW'(a)};
    endfunction

    // |2A| from vertex 1 as origin: (v2-v1) x (v3-v1)
    function automatic longint area2(logic [3*XW-1:0] x,
                                     logic [3*YW-1:0] y);
        longint xs[3];
        longint ys[3];
        longint a;
        for (int i = 0; i < 3; i++) begin
            xs[i] = longint'($signed(x[i*XW +: XW]));
            ys[i] = longint'($signed(y[i*YW +: YW]));
        end
        a = (xs[1] - xs[0]) * (ys[2] - ys[0])
          - (xs[2] - xs[0]) * (ys[1] - ys[0]);
        return (a < 0) ? -a : a;
    endfunction

    always @(negedge clk) begin
        if (rst_n && tri_valid && tri_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_tri", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("tri_x", tri_x, mon_e.x);
                chk("tri_y", tri_y, mon_e.y);
                chk("tri_z", tri_z, mon_e.z);
                chk("tri_color", tri_color, mon_e.c);
                chk("inv_area", inv_area, mon_e.inv);
            end
        end
    end

    task automatic send(input logic [3*XW-1:0] x, input logic [3*YW-1:0] y,
                        input logic [3*ZW-1:0] z, input logic [CW-1:0] c,
                        output int acc);
        longint a;
        exp_t   e;
        in_x = x;
        in_y = y;
        in_z = z;
        in_color = c;
        in_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            a = area2(x, y);
            if (a == 0) begin
                exp_cull++;
            end else begin
                e = '{x, y, z, c, 32'((longint'(1) << FB) / a)};
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_valid(input int acc, output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tri_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain(string nm);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) break;
        end
        chk(nm, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_tri_valid"}, tri_valid, 0);
        chk({tag, "_cull_pulse"}, cull_pulse, 0);
        chk({tag, "_cull_count"}, cull_count, 0);
        chk({tag, "_inv_area"}, inv_area, 0);
        chk({tag, "_tri_xyz"}, longint'(|{tri_x, tri_y, tri_z}), 0);
        chk({tag, "_tri_color"}, tri_color, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, lat, cc0, pulses, vbad, bad;
        logic [3*XW-1:0] sx;
        logic [3*YW-1:0] sy;
        logic [3*ZW-1:0] sz;
        logic [CW-1:0]   sc;
        logic [31:0]     si;
        logic [3*XW-1:0] t1x, t2x, t2sx;
        logic [3*YW-1:0] t1y, t2y, t2sy;
        logic [3*ZW-1:0] t1z;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic triangle, latency and echo
        t1x = px(100, 200, 100);
        t1y = py(50, 150, 150);
        t1z = {16'd50, 16'd50, 16'd50};
        send(t1x, t1y, t1z, 8'hE0, acc);
        wait_valid(acc, lat);
        chk("latency", lat, FB + 2);
        chk("t1_inv", inv_area, 1677);
        drain("t1_drain");

        // 2: CW winding, then v2/v3 swapped
        t2x  = px(200, 150, 250);
        t2y  = py(50, 100, 100);
        t2sx = px(200, 250, 150);
        t2sy = py(50, 100, 100);
        send(t2x, t2y, 48'h1234_5678_9abc, 8'h1C, acc);
        wait_valid(acc, lat);
        chk("t2_inv", inv_area, 3355);
        drain("t2_drain");
        send(t2sx, t2sy, 48'h1234_5678_9abc, 8'h1C, acc);
        wait_valid(acc, lat);
        chk("t2_swap_inv", inv_area, 3355);
        drain("t2s_drain");

        // 3: smallest and largest areas
        send(px(0, 1, 0), py(0, 0, 1), 48'h0, 8'h03, acc);
        wait_valid(acc, lat);
        chk("t3_unit_inv", inv_area, 32'h0100_0000);
        drain("t3_drain");
        send(px(-512, 511, -512), py(-256, -256, 255), 48'hffff_0000_ffff,
             8'hFF, acc);
        drain("t3_max_drain");

        // 4: collinear cull
        cc0 = int'(cull_count);
        send(px(0, 10, 20), py(0, 10, 20), 48'h0, 8'h00, acc);
        pulses = 0;
        vbad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pulses += int'(cull_pulse);
            vbad += int'(tri_valid);
            if (i == 2) chk("t4_in_ready", in_ready, 1);
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_no_valid", vbad, 0);
        chk("t4_cull_count", cull_count, cc0 + 1);
        @(posedge clk);
        #1;

        // 5: backpressure
        tr_fixed = 1'b0;
        send(t1x, t1y, 48'h0001_0002_0003, 8'h5A, acc);
        wait_valid(acc, lat);
        sx = tri_x;
        sy = tri_y;
        sz = tri_z;
        sc = tri_color;
        si = inv_area;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_x = 30'($urandom);
            in_y = 27'($urandom);
            in_color = 8'($urandom);
            @(negedge clk);
            if (!tri_valid || in_ready || tri_x != sx || tri_y != sy ||
                tri_z != sz || tri_color != sc || inv_area != si) bad++;
        end
        chk("t5_stable", bad, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tr_fixed = 1'b1;
        @(negedge clk);
        chk("t5_valid_held", tri_valid, 1);
        @(negedge clk);
        chk("t5_released", tri_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("t5_sb_empty", sb.size(), 0);

        // 6: reset in the middle of the divide
        send(t2x, t2y, 48'h0, 8'h1C, acc);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        sb.delete();
        exp_cull = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vbad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vbad += int'(tri_valid);
        end
        chk("t6_no_stale", vbad, 0);
        @(posedge clk);
        #1;
        send(t1x, t1y, t1z, 8'hE0, acc);
        wait_valid(acc, lat);
        chk("t6_latency", lat, FB + 2);
        chk("t6_inv", inv_area, 1677);
        drain("t6_drain");

        // randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int mode, bx, by;
            logic [3*XW-1:0] rx;
            logic [3*YW-1:0] ry;
            mode = int'($urandom_range(0, 3));
            bx = int'($urandom_range(0, 600)) - 300;
            by = int'($urandom_range(0, 200)) - 100;
            if (mode == 0) begin
                rx = px(bx + int'($urandom_range(0, 16)) - 8,
                        bx + int'($urandom_range(0, 16)) - 8,
                        bx + int'($urandom_range(0, 16)) - 8);
                ry = py(by + int'($urandom_range(0, 16)) - 8,
                        by + int'($urandom_range(0, 16)) - 8,
                        by + int'($urandom_range(0, 16)) - 8);
            end else if (mode == 1) begin
                rx = px(bx, bx + 3, bx + 6);
                ry = py(by, by + 2, by + 4);
            end else begin
                rx = 30'($urandom);
                ry = 27'($urandom);
            end
            send(rx, ry, {16'($urandom), 32'($urandom)}, 8'($urandom), acc);
        end
        drain("rand_drain");
        rand_bp = 1'b0;
        @(negedge clk);
        chk("cull_total", cull_count, exp_cull);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
